phy_rx_decode: RTL and testbench

USB 1.1 full-speed receive decoder, the receive-side counterpart of the PHY TX chain (p2s/nrzi/s2d). It consumes bit-rate line samples from the RX front end (differential receiver plus DPLL strobe) and performs NRZI decode, SYNC detection, bit unstuffing, LSB-first byte assembly and EOP detection. It emits a byte stream with sop/eop/valid/err markers to the link layer. The stream cannot be stalled, so the interface has no ready signal.

---
 rtl/phy_usb_pkg.sv | 17 +
 rtl/phy_rx_nrzi.sv | 59 +++++
 rtl/phy_rx_decode.sv | 193 +++++++++++++++++++
 tb/tb_phy_rx_decode.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/phy_usb_pkg.sv
// rtl/phy_usb_pkg.sv - shared USB full-speed PHY constants and receive state encoding
package phy_usb_pkg;

    localparam logic LINE_J = 1'b1;
    localparam logic LINE_K = 1'b0;

    localparam int STUFF_LEN_DEF  = 6;
    localparam int SYNC_ZEROS_DEF = 6;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_DATA  = 2'd1,
        RX_EOP   = 2'd2,
        RX_ABORT = 2'd3
    } rx_state_t;

endpackage

// File: rtl/phy_rx_nrzi.sv
// rtl/phy_rx_nrzi.sv - NRZI decode and bit unstuffing of recovered line samples
module phy_rx_nrzi
    import phy_usb_pkg::*;
#(
    parameter int STUFF_LEN = STUFF_LEN_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_bit_en,
    input  logic rx_dj,
    input  logic rx_se0,
    input  logic unstuff_en,
    input  logic line_rst,
    output logic dec_bit,
    output logic bit_en,
    output logic se0_en,
    output logic stuff_err
);

    localparam int OW = $clog2(STUFF_LEN + 1);

    logic          prev_line;
    logic [OW-1:0] ones_cnt;
    logic          sample;
    logic          stuff_slot;

    // A stuffed slot only exists inside a packet; outside it every decoded bit is passed on.
    assign sample     = rx_bit_en & ~rx_se0;
    assign dec_bit    = (rx_dj == prev_line);
    assign stuff_slot = unstuff_en && (ones_cnt == OW'(STUFF_LEN));
    assign bit_en     = sample & ~stuff_slot;
    assign stuff_err  = sample & stuff_slot & dec_bit;
    assign se0_en     = rx_bit_en & rx_se0;

    // Previous line state for NRZI; SE0 leaves it alone, return to idle forces J.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_line <= LINE_J;
        end else if (line_rst) begin
            prev_line <= LINE_J;
        end else if (sample) begin
            prev_line <= rx_dj;
        end
    end

    // Run length of decoded 1s, saturating; a stuffed slot always restarts the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_cnt <= '0;
        end else if (sample) begin
            if (stuff_slot || !dec_bit) begin
                ones_cnt <= '0;
            end else if (ones_cnt != OW'(STUFF_LEN)) begin
                ones_cnt <= ones_cnt + OW'(1);
            end
        end
    end

endmodule

// File: rtl/phy_rx_decode.sv
// rtl/phy_rx_decode.sv - USB full-speed receive decoder: SYNC, byte assembly, holdback, EOP
module phy_rx_decode
    import phy_usb_pkg::*;
#(
    parameter int SYNC_ZEROS = SYNC_ZEROS_DEF,
    parameter int STUFF_LEN  = STUFF_LEN_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_bit_en,
    input  logic       rx_dj,
    input  logic       rx_se0,
    output logic       rx_sop,
    output logic       rx_eop,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_err
);

    localparam int ZW = $clog2(SYNC_ZEROS + 1);

    rx_state_t     state_q, state_d;
    logic [ZW-1:0] zero_q, zero_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [2:0]    residue_q, residue_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic          first_q, first_d;
    logic          abort_se0_q, abort_se0_d;
    logic          sop_d, eop_d, valid_d, err_d;
    logic [7:0]    data_d;
    logic [7:0]    shifted;

    logic dec_bit, bit_en, se0_en, stuff_err, line_rst;

    phy_rx_nrzi #(.STUFF_LEN(STUFF_LEN)) u_nrzi (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_bit_en  (rx_bit_en),
        .rx_dj      (rx_dj),
        .rx_se0     (rx_se0),
        .unstuff_en (state_q == RX_DATA),
        .line_rst   (line_rst),
        .dec_bit    (dec_bit),
        .bit_en     (bit_en),
        .se0_en     (se0_en),
        .stuff_err  (stuff_err)
    );

    // Wire order is LSB first, so new bits enter at the top and slide down.
    assign shifted = {dec_bit, shift_q[7:1]};

    // Decoder state, byte assembly and one-byte holdback registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RX_IDLE;
            zero_q      <= '0;
            bit_cnt_q   <= '0;
            residue_q   <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            first_q     <= 1'b0;
            abort_se0_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            zero_q      <= zero_d;
            bit_cnt_q   <= bit_cnt_d;
            residue_q   <= residue_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            first_q     <= first_d;
            abort_se0_q <= abort_se0_d;
        end
    end

    // Registered byte stream towards the link layer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sop   <= 1'b0;
            rx_eop   <= 1'b0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            rx_data  <= 8'h00;
        end else begin
            rx_sop   <= sop_d;
            rx_eop   <= eop_d;
            rx_valid <= valid_d;
            rx_err   <= err_d;
            rx_data  <= data_d;
        end
    end

    // Next-state and output pulses; nothing moves without a bit strobe.
    always_comb begin
        state_d     = state_q;
        zero_d      = zero_q;
        bit_cnt_d   = bit_cnt_q;
        residue_d   = residue_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        first_d     = first_q;
        abort_se0_d = abort_se0_q;
        sop_d       = 1'b0;
        eop_d       = 1'b0;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        data_d      = rx_data;
        line_rst    = 1'b0;

        case (state_q)
            RX_IDLE: begin
                if (se0_en) begin
                    zero_d = '0;
                end else if (bit_en) begin
                    if (!dec_bit) begin
                        if (zero_q < ZW'(SYNC_ZEROS)) zero_d = zero_q + ZW'(1);
                    end else if (zero_q >= ZW'(SYNC_ZEROS)) begin
                        state_d     = RX_DATA;
                        zero_d      = '0;
                        bit_cnt_d   = '0;
                        hold_full_d = 1'b0;
                        first_d     = 1'b1;
                    end else begin
                        zero_d = '0;
                    end
                end
            end

            RX_DATA: begin
                if (se0_en) begin
                    state_d   = RX_EOP;
                    residue_d = bit_cnt_q;
                end else if (stuff_err) begin
                    err_d       = 1'b1;
                    hold_full_d = 1'b0;
                    abort_se0_d = 1'b0;
                    state_d     = RX_ABORT;
                end else if (bit_en) begin
                    shift_d   = shifted;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (hold_full_q) begin
                            valid_d = 1'b1;
                            sop_d   = first_q;
                            data_d  = hold_q;
                            first_d = 1'b0;
                        end
                        hold_d      = shifted;
                        hold_full_d = 1'b1;
                    end
                end
            end

            RX_EOP: begin
                if (bit_en) begin
                    state_d     = RX_IDLE;
                    line_rst    = 1'b1;
                    hold_full_d = 1'b0;
                    if (hold_full_q) begin
                        valid_d = 1'b1;
                        eop_d   = 1'b1;
                        sop_d   = first_q;
                        data_d  = hold_q;
                    end
                    if (rx_dj == LINE_J) begin
                        // a single dribble bit before SE0 is tolerated
                        err_d = hold_full_q && (residue_q > 3'd1);
                    end else begin
                        err_d = 1'b1;
                        eop_d = 1'b1;
                    end
                end
            end

            RX_ABORT: begin
                if (se0_en) begin
                    abort_se0_d = 1'b1;
                end else if (bit_en && abort_se0_q) begin
                    state_d     = RX_IDLE;
                    line_rst    = 1'b1;
                    abort_se0_d = 1'b0;
                end
            end

            default: state_d = RX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_phy_rx_decode.sv
// tb/tb_phy_rx_decode.sv - randomized self-checking bench for phy_rx_decode
module tb_phy_rx_decode;
    import phy_usb_pkg::*;

    localparam int STUFF = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_bit_en = 1'b0;
    logic       rx_dj = 1'b1;
    logic       rx_se0 = 1'b0;
    logic       rx_sop, rx_eop, rx_valid, rx_err;
    logic [7:0] rx_data;

    int total = 0;
    int bad = 0;

    logic [11:0] obs_q[$];
    logic [11:0] exp_q[$];
    logic [7:0]  pkt[$];
    logic        tx_line = 1'b1;
    int          tx_ones = 0;

    phy_rx_decode dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_bit_en (rx_bit_en),
        .rx_dj     (rx_dj),
        .rx_se0    (rx_se0),
        .rx_sop    (rx_sop),
        .rx_eop    (rx_eop),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_err    (rx_err)
    );

    always #10 clk = ~clk;

    function automatic logic [11:0] ev(input logic sop, input logic eop, input logic valid,
                                       input logic err, input logic [7:0] d);
        return {sop, eop, valid, err, (valid ? d : 8'h00)};
    endfunction

    always @(negedge clk) begin
        if (rx_valid || rx_err || rx_sop || rx_eop)
            obs_q.push_back(ev(rx_sop, rx_eop, rx_valid, rx_err, rx_data));
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic send_sym(input logic dj, input logic se0);
        @(negedge clk);
        rx_bit_en = 1'b1;
        rx_dj     = dj;
        rx_se0    = se0;
        @(negedge clk);
        rx_bit_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        if (!b) tx_line = ~tx_line;
        send_sym(tx_line, 1'b0);
    endtask

    task automatic send_sync(input int nzeros);
        for (int i = 0; i < nzeros; i++) send_bit(1'b0);
        send_bit(1'b1);
        tx_ones = 1;
    endtask

    task automatic send_packet(input int nzeros, input int extra, input logic end_k,
                               input logic inject, input int nse0);
        int   nb;
        int   err_at;
        logic err_done;
        logic b;
        nb       = pkt.size();
        err_at   = 0;
        err_done = 1'b0;
        send_sync(nzeros);
        for (int i = 0; i < nb * 8 + extra; i++) begin
            if (i < nb * 8) b = pkt[i / 8][i % 8];
            else b = 1'($urandom_range(0, 1));
            if (tx_ones == STUFF) begin
                if (inject && !err_done) begin
                    send_bit(1'b1);
                    err_done = 1'b1;
                    err_at   = i;
                end else begin
                    send_bit(1'b0);
                end
                tx_ones = 0;
            end
            send_bit(b);
            tx_ones = b ? tx_ones + 1 : 0;
        end
        for (int i = 0; i < nse0; i++) send_sym(1'b0, 1'b1);
        send_sym(end_k ? LINE_K : LINE_J, 1'b0);
        tx_line = LINE_J;
        repeat (3) send_sym(LINE_J, 1'b0);

        if (err_done) begin
            for (int j = 0; j < err_at / 8 - 1; j++)
                exp_q.push_back(ev(j == 0, 1'b0, 1'b1, 1'b0, pkt[j]));
            exp_q.push_back(ev(1'b0, 1'b0, 1'b0, 1'b1, 8'h00));
        end else if (nzeros >= 6) begin
            for (int j = 0; j < nb - 1; j++)
                exp_q.push_back(ev(j == 0, 1'b0, 1'b1, 1'b0, pkt[j]));
            if (nb > 0)
                exp_q.push_back(ev(nb == 1, 1'b1, 1'b1, end_k || (extra >= 2), pkt[nb - 1]));
            else if (end_k)
                exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 1'b1, 8'h00));
        end
    endtask

    task automatic compare(input string tag);
        check({tag, ".count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check(tag, {20'h0, obs_q[i]}, {20'h0, exp_q[i]});
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset.valid", rx_valid, 1'b0);
        check("reset.sop", rx_sop, 1'b0);
        check("reset.eop", rx_eop, 1'b0);
        check("reset.err", rx_err, 1'b0);
        check("reset.data", rx_data, 8'h00);
        rst_n = 1'b1;
        repeat (3) send_sym(LINE_J, 1'b0);

        pkt = '{8'hA5, 8'hC3};  send_packet(7, 0, 1'b0, 1'b0, 2); compare("a5c3");
        pkt = '{8'hFF, 8'h7E};  send_packet(7, 0, 1'b0, 1'b0, 2); compare("stuffed");
        pkt = '{8'hFF};         send_packet(7, 0, 1'b0, 1'b1, 2); compare("stuff_err");
        pkt = '{8'h12};         send_packet(7, 1, 1'b0, 1'b0, 2); compare("dribble1");
        pkt = '{8'h12};         send_packet(7, 3, 1'b0, 1'b0, 2); compare("dribble3");
        pkt = '{8'h3C, 8'h99};  send_packet(6, 0, 1'b0, 1'b0, 1); compare("short_sync");
        pkt = '{8'hA5};         send_packet(5, 0, 1'b0, 1'b0, 2); compare("sync5");
        pkt = '{8'h55};         send_packet(7, 0, 1'b1, 1'b0, 2); compare("k_end");
        pkt = '{};              send_packet(7, 0, 1'b0, 1'b0, 2); compare("sync_only");

        pkt = '{8'h3C, 8'h81};
        send_sync(7);
        for (int i = 0; i < 12; i++) send_bit(pkt[i / 8][i % 8]);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst.valid", rx_valid, 1'b0);
        check("rst.sop", rx_sop, 1'b0);
        check("rst.eop", rx_eop, 1'b0);
        check("rst.err", rx_err, 1'b0);
        check("rst.data", rx_data, 8'h00);
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        tx_line = LINE_J;
        repeat (3) send_sym(LINE_J, 1'b0);
        compare("rst_quiet");
        pkt = '{8'h5A, 8'h0F};  send_packet(7, 0, 1'b0, 1'b0, 2); compare("after_rst");

        for (int p = 0; p < 25; p++) begin
            int nb;
            nb = $urandom_range(0, 4);
            pkt.delete();
            for (int j = 0; j < nb; j++)
                pkt.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
            send_packet($urandom_range(6, 8), $urandom_range(0, 3),
                        ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
                        $urandom_range(1, 3));
            compare("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
